cim_share_arbiter: RTL and testbench

CIM_SHARE_ARBITER -- requirements
Module: cim_share_arbiter

---
 rtl/cim_share_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_cim_share_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_share_arbiter.sv
// Round-robin arbiter letting NUM_REQ layer controllers time-share one CIM tile array.
// Latency: grant is registered 1 cycle after a request is seen in IDLE; CIM controls are muxed combinationally.
// Backpressure: the owner holds the array from grant until its start completes (ready low then high) or it drops i_req.
//
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   i_req/o_gnt/o_owner   - per-requester level requests, one-hot-or-zero registered grant, owner index
//   i_req_we/start/addr/data - per-requester CIM controls (packed, requester k at slice k)
//   o_req_cim_ready       - i_cim_ready forwarded to the owner only
//   i_cim_ready, o_cim_*  - CIM tile array handshake and muxed controls
//   o_busy                - high whenever the arbiter is not idle
module cim_share_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDR_WIDTH = 4,
  parameter  int DATA_WIDTH = 16,
  localparam int OWN_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            i_req,
  output logic [NUM_REQ-1:0]            o_gnt,
  input  logic [NUM_REQ-1:0]            i_req_we,
  input  logic [NUM_REQ-1:0]            i_req_start,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_cim_ready,
  input  logic                          i_cim_ready,
  output logic                          o_cim_we,
  output logic                          o_cim_start,
  output logic [ADDR_WIDTH-1:0]         o_cim_rd_addr,
  output logic [DATA_WIDTH-1:0]         o_cim_data,
  output logic                          o_busy,
  output logic [OWN_W-1:0]              o_owner
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [OWN_W-1:0]     ptr_q, ptr_d;

  // Round-robin search result
  logic                 sel_found;
  logic [OWN_W-1:0]     sel_idx;
  logic [OWN_W:0]       cand;

  // Pointer value used on release: owner + 1, wrapped
  logic [OWN_W:0]       inc;
  logic [OWN_W-1:0]     nxt_ptr;

  // Owner's view of the request bus (all zero when nothing is granted)
  logic                  own_req;
  logic                  own_we;
  logic                  own_start;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [DATA_WIDTH-1:0] own_data;

  logic                  release_own;

  // Scan from ptr upwards; ptr and i are both below NUM_REQ, so one
  // conditional subtraction is enough to wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (OWN_W+1)'(i);
      if (cand >= (OWN_W+1)'(NUM_REQ)) begin
        cand = cand - (OWN_W+1)'(NUM_REQ);
      end
      if (!sel_found && i_req[cand[OWN_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[OWN_W-1:0];
      end
    end
  end

  always_comb begin
    inc = {1'b0, owner_q} + (OWN_W+1)'(1);
    if (inc >= (OWN_W+1)'(NUM_REQ)) begin
      inc = '0;
    end
    nxt_ptr = inc[OWN_W-1:0];
  end

  // One-hot grant makes an OR-style mux safe: at most one slice is picked.
  always_comb begin
    own_req   = 1'b0;
    own_we    = 1'b0;
    own_start = 1'b0;
    own_addr  = '0;
    own_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_q[k]) begin
        own_req   = i_req[k];
        own_we    = i_req_we[k];
        own_start = i_req_start[k];
        own_addr  = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        own_data  = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    release_own = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_cim_ready && sel_found) begin
          gnt_d   = NUM_REQ'(1) << sel_idx;
          owner_d = sel_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Start takes priority over a simultaneous request drop.
        if (own_start) begin
          state_d = WAIT_BUSY;
        end else if (!own_req) begin
          release_own = 1'b1;
        end
      end
      WAIT_BUSY: begin
        if (!i_cim_ready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_cim_ready) begin
          release_own = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        owner_d = '0;
      end
    endcase
    // Releasing always passes through IDLE, so grants are never back-to-back.
    if (release_own) begin
      state_d = IDLE;
      gnt_d   = '0;
      owner_d = '0;
      ptr_d   = nxt_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_gnt           = gnt_q;
  assign o_owner         = owner_q;
  assign o_busy          = (state_q != IDLE);
  assign o_req_cim_ready = gnt_q & {NUM_REQ{i_cim_ready}};
  // Once a start is accepted the owner can no longer write or restart;
  // address/data stay on the owner for the duration of the operation.
  assign o_cim_we        = (state_q == GRANT) && own_we;
  assign o_cim_start     = (state_q == GRANT) && own_start;
  assign o_cim_rd_addr   = own_addr;
  assign o_cim_data      = own_data;

endmodule

// File: tb/tb_cim_share_arbiter.sv
// Testbench for cim_share_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
// Inputs change on the falling edge; outputs are compared 1 time unit later.
module tb_cim_share_arbiter;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int OW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, gnt, we, start, rdy_out;
  logic [N*AW-1:0] addr_bus;
  logic [N*DW-1:0] data_bus;
  logic            ready;
  logic            cim_we, cim_start, busy;
  logic [AW-1:0]   cim_addr;
  logic [DW-1:0]   cim_data;
  logic [OW-1:0]   owner;

  int n_vec = 0;
  int n_err = 0;
  int exp_order [5] = '{0, 1, 2, 3, 0};

  // Reference model: who owns the array, whether its start was taken,
  // and whether the CIM has gone busy since.
  int m_owner = -1;
  int m_ptr   = 0;
  bit m_started = 1'b0;
  bit m_low_seen = 1'b0;

  cim_share_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req           (req),
    .o_gnt           (gnt),
    .i_req_we        (we),
    .i_req_start     (start),
    .i_req_addr      (addr_bus),
    .i_req_data      (data_bus),
    .o_req_cim_ready (rdy_out),
    .i_cim_ready     (ready),
    .o_cim_we        (cim_we),
    .o_cim_start     (cim_start),
    .o_cim_rd_addr   (cim_addr),
    .o_cim_data      (cim_data),
    .o_busy          (busy),
    .o_owner         (owner)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner    = -1;
    m_ptr      = 0;
    m_started  = 1'b0;
    m_low_seen = 1'b0;
  endfunction

  function automatic void release_owner();
    m_ptr      = (m_owner + 1) % N;
    m_owner    = -1;
    m_started  = 1'b0;
    m_low_seen = 1'b0;
  endfunction

  function automatic void model_step();
    if (!rst) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (ready && req != '0) begin
        for (int i = 0; i < N; i++) begin
          if (m_owner < 0 && req[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
        end
      end
    end else if (!m_started) begin
      if (start[m_owner]) begin
        m_started  = 1'b1;
        m_low_seen = 1'b0;
      end else if (!req[m_owner]) begin
        release_owner();
      end
    end else if (!m_low_seen) begin
      if (!ready) m_low_seen = 1'b1;
    end else if (ready) begin
      release_owner();
    end
  endfunction

  task automatic check_all();
    logic [N-1:0]  eg;
    logic          ewe, est;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    eg = '0; ewe = 1'b0; est = 1'b0; ea = '0; ed = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ea = addr_bus[m_owner*AW +: AW];
      ed = data_bus[m_owner*DW +: DW];
      if (!m_started) begin
        ewe = we[m_owner];
        est = start[m_owner];
      end
    end
    chk("gnt",     64'(gnt),            64'(eg));
    chk("onehot0", 64'($onehot0(gnt)),  64'd1);
    chk("owner",   64'(owner),          (m_owner >= 0) ? 64'(m_owner) : 64'd0);
    chk("busy",    64'(busy),           64'(m_owner >= 0));
    chk("cim_we",  64'(cim_we),         64'(ewe));
    chk("cim_start", 64'(cim_start),    64'(est));
    chk("cim_addr", 64'(cim_addr),      64'(ea));
    chk("cim_data", 64'(cim_data),      64'(ed));
    chk("req_rdy", 64'(rdy_out),        ready ? 64'(eg) : 64'd0);
  endtask

  // Called on a falling edge after inputs are set; returns on the next falling edge.
  task automatic cycle();
    #1;
    if (!rst) model_reset();
    check_all();
    model_step();
    @(negedge clk);
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (gnt == '0 && n < 12) begin
      cycle();
      n++;
    end
    chk("gnt_wait_bound", 64'(gnt != '0), 64'd1);
  endtask

  task automatic set_addr(input int k, input logic [AW-1:0] v);
    addr_bus[k*AW +: AW] = v;
  endtask

  initial begin
    int w;
    rst = 1'b0; req = '0; we = '0; start = '0; ready = 1'b1;
    addr_bus = '0; data_bus = '0;
    @(negedge clk);
    cycle();
    cycle();

    // All four requesting at reset release, CIM cycling busy/ready.
    req = '1;
    rst = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wait_gnt(w);
      chk("rr_latency", 64'(w), 64'd1);
      chk("rr_order", 64'(owner), 64'(exp_order[j]));
      start[owner] = 1'b1;
      cycle();
      start = '0;
      ready = 1'b0;
      cycle();
      cycle();
      ready = 1'b1;
      if (j == 4) req = '0;
      cycle();
      chk("rr_released", 64'(gnt), 64'd0);
    end
    cycle();

    // Requester 2 alone: three writes, then a start and a busy period.
    req = 4'b0100;
    data_bus = 64'h1111_2222_3333_4444;
    wait_gnt(w);
    chk("r2_owner", 64'(owner), 64'd2);
    for (int a = 5; a <= 7; a++) begin
      we = 4'b0101;
      set_addr(2, AW'(a));
      set_addr(0, 4'hF);
      #1;
      chk("r2_addr", 64'(cim_addr), 64'(a));
      chk("r2_we", 64'(cim_we), 64'd1);
      cycle();
    end
    we = '0;
    start = 4'b0100;
    #1;
    chk("r2_start_pulse", 64'(cim_start), 64'd1);
    chk("r2_addr_at_start", 64'(cim_addr), 64'd7);
    cycle();
    start = '0;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    ready = 1'b1;
    req = '0;
    #1;
    chk("r2_done_rdy", 64'(rdy_out), 64'h4);
    cycle();
    chk("r2_gnt_after_done", 64'(gnt), 64'd0);

    // Owner 1 drops its request without starting.
    req = 4'b0010;
    wait_gnt(w);
    chk("r1_owner", 64'(owner), 64'd1);
    req = '0;
    #1;
    chk("r1_no_start", 64'(cim_start), 64'd0);
    cycle();
    chk("r1_released", 64'(gnt), 64'd0);
    req = '1;
    wait_gnt(w);
    chk("ptr_after_drop", 64'(owner), 64'd2);
    req = '0;
    cycle();

    // Requester 3 tries to start while requester 0 owns the array.
    req = 4'b0001;
    wait_gnt(w);
    chk("r0_owner", 64'(owner), 64'd0);
    req = 4'b1001;
    start = 4'b1000;
    we = 4'b1000;
    #1;
    chk("r3_start_blocked", 64'(cim_start), 64'd0);
    chk("r3_we_blocked", 64'(cim_we), 64'd0);
    chk("r3_rdy_blocked", 64'(rdy_out[3]), 64'd0);
    cycle();
    cycle();
    chk("r0_still_owner", 64'(gnt), 64'd1);
    start = '0; we = '0; req = '0;
    cycle();

    // Reset during WAIT_DONE aborts the transaction.
    req = 4'b0100;
    set_addr(2, 4'h9);
    wait_gnt(w);
    start = 4'b0100;
    cycle();
    start = '0;
    ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", 64'(cim_addr), 64'd0);
    chk("rst_data", 64'(cim_data), 64'd0);
    cycle();
    ready = 1'b1;
    req = 4'b1010;
    rst = 1'b1;
    wait_gnt(w);
    chk("rst_first_gnt", 64'(owner), 64'd1);
    req = '0;
    cycle();

    // CIM not ready in IDLE: nothing is granted until it rises.
    ready = 1'b0;
    req = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("notready_no_gnt", 64'(gnt), 64'd0);
    end
    ready = 1'b1;
    wait_gnt(w);
    chk("notready_then_gnt", 64'(owner), 64'd3);
    req = '0;
    cycle();

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      req      = N'($urandom);
      we       = N'($urandom);
      start    = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
      ready    = ($urandom_range(0, 3) != 0);
      addr_bus = (N*AW)'($urandom);
      data_bus = {$urandom, $urandom};
      rst      = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
